// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
// Opcode classes, FSM states and the IF/ID bundle.
package fetch_pkg;

    localparam int PC_BITS = 8;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        INT  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [7:0] HLT_INSTR = 8'h01;

    localparam logic [3:0] OP_LDM  = 4'hC;
    localparam logic [3:0] OP_LDD  = 4'hD;
    localparam logic [3:0] OP_JMPI = 4'hE;

    typedef struct packed {
        logic [7:0]         instr;
        logic [7:0]         imm;
        logic [PC_BITS-1:0] pc_next;
    } if_id_t;

    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDM) || (op == OP_LDD) || (op == OP_JMPI);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and clear.
// Clear squashes valid only; the payload is kept.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  logic   hold_i,
    input  logic   load_i,
    input  if_id_t data_i,
    output logic   valid_o,
    output if_id_t data_o
);

    logic   valid_q;
    if_id_t data_q;

    // Clear beats hold beats load; idle cycles insert a bubble
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            valid_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, length decode, stall/branch/HLT/interrupt.
// Feeds the IF/ID register one edge after pc is presented.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int         PC_W            = PC_BITS,
    parameter logic [7:0] RST_PC_FALLBACK = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            interrupt,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic [7:0]      instr_in,
    input  logic [7:0]      next_byte_in,
    input  logic [PC_W-1:0] vec_in,
    output logic [PC_W-1:0] pc_out,
    output logic            ifid_valid,
    output logic [7:0]      ifid_instr,
    output logic [7:0]      ifid_imm,
    output logic [PC_W-1:0] ifid_pc_next,
    output logic            int_ack,
    output logic [PC_W-1:0] int_ret_pc
);

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] ret_q;
    logic            pend_q;
    logic            prev_q;
    logic            ack_q;

    logic            two_byte;
    logic [PC_W-1:0] pc_d;
    logic            int_edge;
    logic            fetch_go;
    logic            take_int;
    logic            ifid_hold;
    logic            ifid_clear;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    // Length decode, next PC and IF/ID control
    always_comb begin
        two_byte   = is_two_byte(instr_in[7:4]);
        pc_d       = pc_q + (two_byte ? PC_W'(2) : PC_W'(1));
        int_edge   = interrupt & ~prev_q;
        fetch_go   = (state_q == RUN) && !branch_taken
                     && !stall && !pend_q;
        take_int   = pend_q && !branch_taken && !stall
                     && (state_q != INT);
        ifid_hold  = stall && !branch_taken && (state_q != INT);
        ifid_clear = !fetch_go && !ifid_hold;
        ifid_d.instr   = instr_in;
        ifid_d.imm     = two_byte ? next_byte_in : 8'h00;
        ifid_d.pc_next = pc_d;
    end

    // Fetch FSM: PC, interrupt latch and entry bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= vec_in;
            ret_q   <= '0;
            pend_q  <= 1'b0;
            prev_q  <= interrupt;
            ack_q   <= 1'b0;
        end else begin
            prev_q <= interrupt;
            ack_q  <= 1'b0;
            pend_q <= pend_q | int_edge;
            if (branch_taken) begin
                pc_q    <= branch_target;
                state_q <= RUN;
            end else if (take_int) begin
                ret_q   <= pc_q;
                pc_q    <= vec_in;
                ack_q   <= 1'b1;
                pend_q  <= int_edge;
                state_q <= INT;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (fetch_go) begin
                            pc_q <= pc_d;
                            if (instr_in == HLT_INSTR) begin
                                state_q <= HALT;
                            end
                        end
                    end
                    INT:     state_q <= RUN;
                    HALT:    state_q <= HALT;
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    ifid_reg u_ifid (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (ifid_clear),
        .hold_i  (ifid_hold),
        .load_i  (fetch_go),
        .data_i  (ifid_d),
        .valid_o (ifid_valid),
        .data_o  (ifid_q)
    );

    assign pc_out       = pc_q;
    assign ifid_instr   = ifid_q.instr;
    assign ifid_imm     = ifid_q.imm;
    assign ifid_pc_next = ifid_q.pc_next;
    assign int_ack      = ack_q;
    assign int_ret_pc   = ret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       interrupt;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] instr_in;
    logic [7:0] next_byte_in;
    logic [7:0] vec_in;
    logic [7:0] pc_out;
    logic       ifid_valid;
    logic [7:0] ifid_instr;
    logic [7:0] ifid_imm;
    logic [7:0] ifid_pc_next;
    logic       int_ack;
    logic [7:0] int_ret_pc;

    logic [7:0] rom [256];
    logic [7:0] rst_vec;
    logic [7:0] int_vec;
    logic [7:0] pc_plus1;

    int checks   = 0;
    int failures = 0;

    // model state; mode 0=running 1=int entry 2=halted
    int         m_mode;
    logic [7:0] m_pc, m_ret, m_i, m_imm, m_pcn;
    logic       m_pend, m_prev, m_ack, m_v;

    always #5 clk = ~clk;

    assign pc_plus1     = pc_out + 8'd1;
    assign instr_in     = rom[pc_out];
    assign next_byte_in = rom[pc_plus1];
    assign vec_in       = rst ? rst_vec : int_vec;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .interrupt     (interrupt),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .next_byte_in  (next_byte_in),
        .vec_in        (vec_in),
        .pc_out        (pc_out),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_imm      (ifid_imm),
        .ifid_pc_next  (ifid_pc_next),
        .int_ack       (int_ack),
        .int_ret_pc    (int_ret_pc)
    );

    // advance one clock and the model alongside it
    task automatic tick();
        int         n_mode;
        logic [7:0] n_pc, n_ret, n_i, n_imm, n_pcn, op, a1;
        logic       n_pend, n_prev, n_ack, n_v, e, two, enter;
        n_mode = m_mode; n_pc = m_pc; n_ret = m_ret;
        n_i = m_i; n_imm = m_imm; n_pcn = m_pcn;
        n_pend = m_pend; n_ack = m_ack; n_v = m_v;
        n_prev = interrupt;
        enter  = 1'b0;
        e = interrupt && !m_prev;
        if (rst) begin
            n_mode = 0; n_pc = rst_vec; n_ret = 8'h00;
            n_pend = 1'b0; n_ack = 1'b0; n_v = 1'b0;
            n_i = 8'h00; n_imm = 8'h00; n_pcn = 8'h00;
        end else begin
            n_ack  = 1'b0;
            n_pend = m_pend | e;
            if (m_mode == 0) begin
                if (branch_taken) begin
                    n_pc = branch_target; n_v = 1'b0;
                end else if (stall) begin
                end else if (m_pend) begin
                    enter = 1'b1;
                end else begin
                    op  = rom[m_pc];
                    a1  = m_pc + 8'd1;
                    two = (op[7:4] >= 4'hC) && (op[7:4] <= 4'hE);
                    n_v = 1'b1; n_i = op;
                    n_imm = two ? rom[a1] : 8'h00;
                    n_pc  = m_pc + (two ? 8'd2 : 8'd1);
                    n_pcn = n_pc;
                    if (op == 8'h01) n_mode = 2;
                end
            end else if (m_mode == 1) begin
                n_mode = 0; n_v = 1'b0;
                if (branch_taken) n_pc = branch_target;
            end else begin
                if (branch_taken) begin
                    n_pc = branch_target; n_mode = 0; n_v = 1'b0;
                end else if (!stall) begin
                    n_v = 1'b0;
                    if (m_pend) enter = 1'b1;
                end
            end
            if (enter) begin
                n_ret = m_pc; n_pc = int_vec; n_v = 1'b0;
                n_ack = 1'b1; n_pend = e; n_mode = 1;
            end
        end
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_ret = n_ret;
        m_i = n_i; m_imm = n_imm; m_pcn = n_pcn;
        m_pend = n_pend; m_prev = n_prev; m_ack = n_ack; m_v = n_v;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_vec = 8'h20; interrupt = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        tick(); tick();
        checks++;
        if (pc_out !== 8'h20) begin
            failures++; $display("FAIL rst_pc got=%h exp=20", pc_out);
        end
        checks++;
        if (ifid_valid !== 1'b0 || int_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags got v=%b ack=%b exp 0 0",
                     ifid_valid, int_ack);
        end
        checks++;
        if (int_ret_pc !== 8'h00 || ifid_instr !== 8'h00) begin
            failures++;
            $display("FAIL rst_regs got ret=%h instr=%h exp 00 00",
                     int_ret_pc, ifid_instr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 8'h35 ||
            ifid_imm !== 8'h00 || ifid_pc_next !== 8'h21) begin
            failures++;
            $display("FAIL first_fetch got v=%b i=%h imm=%h pcn=%h exp 1 35 00 21",
                     ifid_valid, ifid_instr, ifid_imm, ifid_pc_next);
        end
    endtask

    task automatic test_two_byte();
        tick();
        checks++;
        if (ifid_instr !== 8'hC4 || ifid_imm !== 8'h7F ||
            ifid_pc_next !== 8'h23 || pc_out !== 8'h23) begin
            failures++;
            $display("FAIL two_byte got i=%h imm=%h pcn=%h pc=%h exp C4 7F 23 23",
                     ifid_instr, ifid_imm, ifid_pc_next, pc_out);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 8'hFF;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc_out !== 8'hFF || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_branch got pc=%h v=%b exp FF 0",
                     pc_out, ifid_valid);
        end
        tick();
        checks++;
        if (ifid_instr !== 8'hD0 || ifid_imm !== 8'h55 ||
            pc_out !== 8'h01 || ifid_pc_next !== 8'h01) begin
            failures++;
            $display("FAIL wrap got i=%h imm=%h pc=%h pcn=%h exp D0 55 01 01",
                     ifid_instr, ifid_imm, pc_out, ifid_pc_next);
        end
    endtask

    task automatic test_stall_branch();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pc_out !== 8'h01 || ifid_valid !== 1'b1 ||
                ifid_instr !== 8'hD0 || ifid_imm !== 8'h55 ||
                ifid_pc_next !== 8'h01 || int_ack !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got pc=%h v=%b i=%h imm=%h pcn=%h exp 01 1 D0 55 01",
                         pc_out, ifid_valid, ifid_instr, ifid_imm, ifid_pc_next);
            end
        end
        branch_taken = 1'b1; branch_target = 8'h40;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        checks++;
        if (pc_out !== 8'h40 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_branch got pc=%h v=%b exp 40 0",
                     pc_out, ifid_valid);
        end
    endtask

    task automatic test_interrupt();
        int_vec = 8'h80;
        branch_taken = 1'b1; branch_target = 8'h30; interrupt = 1'b1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc_out !== 8'h30 || int_ack !== 1'b0) begin
            failures++;
            $display("FAIL int_pre got pc=%h ack=%b exp 30 0", pc_out, int_ack);
        end
        tick();
        checks++;
        if (int_ack !== 1'b1 || int_ret_pc !== 8'h30 ||
            pc_out !== 8'h80 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL int_entry got ack=%b ret=%h pc=%h v=%b exp 1 30 80 0",
                     int_ack, int_ret_pc, pc_out, ifid_valid);
        end
        tick();
        checks++;
        if (int_ack !== 1'b0 || ifid_valid !== 1'b0 || pc_out !== 8'h80) begin
            failures++;
            $display("FAIL int_bubble got ack=%b v=%b pc=%h exp 0 0 80",
                     int_ack, ifid_valid, pc_out);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 8'h10 || pc_out !== 8'h81) begin
            failures++;
            $display("FAIL int_resume got v=%b i=%h pc=%h exp 1 10 81",
                     ifid_valid, ifid_instr, pc_out);
        end
        interrupt = 1'b0;
        tick();
        interrupt = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 8'h60;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc_out !== 8'h60 || int_ack !== 1'b0) begin
            failures++;
            $display("FAIL int_br_first got pc=%h ack=%b exp 60 0",
                     pc_out, int_ack);
        end
        tick();
        checks++;
        if (int_ack !== 1'b1 || int_ret_pc !== 8'h60 || pc_out !== 8'h80) begin
            failures++;
            $display("FAIL int_after_br got ack=%b ret=%h pc=%h exp 1 60 80",
                     int_ack, int_ret_pc, pc_out);
        end
        tick();
        interrupt = 1'b0;
    endtask

    task automatic test_hlt();
        branch_taken = 1'b1; branch_target = 8'h50;
        tick();
        branch_taken = 1'b0;
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 8'h01 || pc_out !== 8'h51) begin
            failures++;
            $display("FAIL hlt_issue got v=%b i=%h pc=%h exp 1 01 51",
                     ifid_valid, ifid_instr, pc_out);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (ifid_valid !== 1'b0 || pc_out !== 8'h51 || int_ack !== 1'b0) begin
                failures++;
                $display("FAIL hlt_hold got v=%b pc=%h ack=%b exp 0 51 0",
                         ifid_valid, pc_out, int_ack);
            end
        end
        interrupt = 1'b1;
        tick();
        tick();
        checks++;
        if (int_ack !== 1'b1 || int_ret_pc !== 8'h51 || pc_out !== 8'h80) begin
            failures++;
            $display("FAIL hlt_int got ack=%b ret=%h pc=%h exp 1 51 80",
                     int_ack, int_ret_pc, pc_out);
        end
        interrupt = 1'b0;
        tick(); tick();
        branch_taken = 1'b1; branch_target = 8'h50;
        tick();
        branch_taken = 1'b0;
        tick(); tick();
        rst = 1'b1; rst_vec = 8'h20;
        tick();
        rst = 1'b0;
        checks++;
        if (pc_out !== 8'h20 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL hlt_rst got pc=%h v=%b exp 20 0", pc_out, ifid_valid);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 8'h35 || pc_out !== 8'h21) begin
            failures++;
            $display("FAIL hlt_rst_run got v=%b i=%h pc=%h exp 1 35 21",
                     ifid_valid, ifid_instr, pc_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) begin
            rom[i] = ($urandom_range(0, 15) == 0) ? 8'h01 : 8'($urandom);
        end
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            rst_vec       = 8'($urandom);
            int_vec       = 8'($urandom);
            stall         = (m_mode == 0) && ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = 8'($urandom);
            if ($urandom_range(0, 5) == 0) interrupt = ~interrupt;
            tick();
            checks++;
            if (pc_out !== m_pc || ifid_valid !== m_v ||
                int_ack !== m_ack || int_ret_pc !== m_ret) begin
                failures++;
                $display("FAIL rnd_ctrl n=%0d got pc=%h v=%b ack=%b ret=%h exp %h %b %b %h",
                         n, pc_out, ifid_valid, int_ack, int_ret_pc,
                         m_pc, m_v, m_ack, m_ret);
            end
            if (m_v) begin
                checks++;
                if (ifid_instr !== m_i || ifid_imm !== m_imm ||
                    ifid_pc_next !== m_pcn) begin
                    failures++;
                    $display("FAIL rnd_ifid n=%0d got i=%h imm=%h pcn=%h exp %h %h %h",
                             n, ifid_instr, ifid_imm, ifid_pc_next,
                             m_i, m_imm, m_pcn);
                end
            end
        end
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h10;
        rom[8'h20] = 8'h35;
        rom[8'h21] = 8'hC4;
        rom[8'h22] = 8'h7F;
        rom[8'hFF] = 8'hD0;
        rom[8'h00] = 8'h55;
        rom[8'h50] = 8'h01;
        int_vec = 8'h80;
        m_mode = 0; m_pc = 8'h00; m_ret = 8'h00;
        m_i = 8'h00; m_imm = 8'h00; m_pcn = 8'h00;
        m_pend = 1'b0; m_prev = 1'b0; m_ack = 1'b0; m_v = 1'b0;
        test_reset();
        test_two_byte();
        test_wrap();
        test_stall_branch();
        test_interrupt();
        test_hlt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 8-bit pipeline: owns the PC, drives it to the instruction ROM, and takes back the opcode byte plus the following byte.
- Decodes instruction length (1 or 2 bytes) and loads the IF/ID pipeline register.
- Handles stall, branch redirect, HLT, and the edge-triggered external interrupt.
- Reset and interrupt vectors arrive on one shared vector input from the ROM.

Parameters:
- PC_W, 8, PC/address width; ROM wraps modulo 2^PC_W.
- RST_PC_FALLBACK, 8'h00, unused by logic; documents the PC value while vec_in is undriven in simulation.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- interrupt  in  1  external interrupt request; rising edge is latched
- stall  in  1  hazard unit: freeze PC and IF/ID
- branch_taken  in  1  redirect request from a later stage
- branch_target  in  8  redirect address
- instr_in  in  8  ROM byte at pc_out
- next_byte_in  in  8  ROM byte at pc_out+1 (wraps)
- vec_in  in  8  reset vector while rst=1, interrupt vector otherwise (top level handles the mapping)
- pc_out  out  8  current fetch address
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  8  fetched opcode byte
- ifid_imm  out  8  second byte for 2-byte instructions, else 8'h00
- ifid_pc_next  out  8  address of the following instruction
- int_ack  out  1  one-cycle pulse when the interrupt is taken
- int_ret_pc  out  8  return address saved at interrupt entry

Behaviour:
- Reset (rst=1 on a clock edge):
  - pc <= vec_in; state <= RUN; int_pending <= 0; int_ack <= 0; int_ret_pc <= 0.
  - ifid_valid/instr/imm/pc_next <= 0.
  - Interrupt edge detector is cleared (previous-interrupt sample <= interrupt).
- Interrupt latch: int_pending is set on a sampled 0->1 edge of interrupt in any state. It is cleared only on interrupt entry. An edge arriving in the same cycle as entry sets a new pending request.
- Length decode: two_byte = opcode (instr_in[7:4]) is in the package TWO_BYTE set; len = two_byte ? 2 : 1.
- Per-cycle priority: rst > branch_taken > stall > interrupt entry > normal fetch.
- State RUN:
  - branch_taken: pc <= branch_target; ifid_valid <= 0. Any pending interrupt stays pending.
  - stall (no branch): pc and all ifid_* hold; int_ack <= 0.
  - int_pending: enter INT. int_ret_pc <= pc; pc <= vec_in; ifid_valid <= 0; int_ack <= 1; int_pending <= 0.
  - Normal fetch:
    - ifid_valid <= 1; ifid_instr <= instr_in; ifid_imm <= two_byte ? next_byte_in : 0.
    - ifid_pc_next <= pc+len mod 256; pc <= pc+len.
    - If instr_in == HLT_INSTR, state <= HALT.
- State INT (exactly one cycle): int_ack <= 0; state <= RUN; ifid_valid <= 0. branch_taken in this cycle is honoured (pc <= branch_target). No fetch is issued.
- State HALT: pc held; ifid_valid <= 0.
  - branch_taken: pc <= branch_target, state <= RUN (an older branch squashes the HLT).
  - int_pending and no stall: interrupt entry as in RUN, with int_ret_pc = pc (the address after HLT).
  - Otherwise remain in HALT.
- Latency: the byte at pc_out appears on ifid_* one edge later. One fetch per cycle when not stalled.
- Wrap: pc=8'hFF with a 2-byte opcode gives imm from address 0x00, and pc and ifid_pc_next become 8'h01.
- int_ack is high for exactly one cycle per taken interrupt and never during stall.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {RUN, INT, HALT}.
  - HLT_INSTR = 8'h01.
  - TWO_BYTE opcode constants 4'hC (LDM), 4'hD (LDD/STD), 4'hE (JMP-imm).
  - Function is_two_byte(opcode).
- One natural sub-module: ifid_reg, the IF/ID pipeline register with valid, hold (stall) and clear (squash) controls, reused by later stage registers.
- Length decode and the FSM stay in fetch_unit.

Test Plan:
- Reset sequence: rst=1 for 2 cycles with vec_in=8'h20, then release -> pc_out=8'h20, ifid_valid=0; first fetched byte 8'h35 at 8'h20 -> next cycle ifid_instr=8'h35, imm=0, pc_next=8'h21.
- Two-byte decode: ROM[0x21]=8'hC4, ROM[0x22]=8'h7F -> ifid_imm=8'h7F, ifid_pc_next=8'h23, pc_out=8'h23.
- Wrap boundary: pc=8'hFF with ROM[0xFF]=8'hD0, ROM[0x00]=8'h55 -> imm=8'h55, pc_out=8'h01.
- Stall and branch: stall=1 for 3 cycles -> pc_out and ifid_* unchanged; stall=1 with branch_taken=1, target=8'h40 -> pc_out=8'h40, ifid_valid=0 next cycle.
- Interrupt: rising edge at pc=8'h30 with vec_in=8'h80 -> int_ack for 1 cycle, int_ret_pc=8'h30, pc_out=8'h80, one bubble. Same-cycle branch_taken=1 -> branch first, interrupt taken the following cycle.
- HLT: fetch 8'h01 at 8'h50 -> HLT issued valid once, then bubbles with pc_out=8'h51 held. Interrupt edge -> int_ret_pc=8'h51, pc=vec. Mid-HALT rst=1 -> pc=vec_in, state RUN.
